// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - Ethernet header constants, capture state encoding and small helpers
package eth_pkg;

  localparam logic [47:0] ETH_BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam int          DST_OFF       = 0;
  localparam int          TYPE_OFF      = 12;
  localparam int          HDR_LEN       = 14;
  localparam logic [15:0] ETHERTYPE_DEF = 16'hEBEB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2,
    ST_HOLD = 2'd3
  } cap_state_t;

  // Byte idx of a MAC address as it appears on the wire (most significant byte first).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    return 8'(mac >> (6'd40 - {idx, 3'b000}));
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/rx_buf_ram.sv
// rtl/rx_buf_ram.sv - simple dual-port frame buffer, one write port and one registered read port
module rx_buf_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_dat
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Only the read register is reset; the array keeps its contents across reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_dat <= 8'd0;
    else        rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/rx_pkt_capture.sv
// rtl/rx_pkt_capture.sv - captures one addressed, typed Ethernet frame from the MAC byte stream and holds it for readout
module rx_pkt_capture
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h020000000001,
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_DEF,
  parameter int          DEPTH     = 64
) (
  input  logic                     clk_mac,
  input  logic                     rst_n,
  input  logic                     rx_vld,
  input  logic [7:0]               rx_dat,
  input  logic                     rx_sof,
  input  logic                     rx_eof,
  input  logic [10:0]              rx_len,
  input  logic                     rx_err,
  output logic                     pkt_rdy,
  output logic [10:0]              pkt_len,
  output logic                     pkt_trunc,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [7:0]               rd_dat,
  input  logic                     pkt_rel,
  output logic [15:0]              good_cnt,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  cap_state_t  state, state_nxt;
  logic [10:0] idx, idx_nxt, pos, addr_pos;
  logic        mac_ok, bc_ok, mac_ok_n, bc_ok_n;
  logic        skip, skip_nxt;
  logic        start, frame_byte, in_dst, hdr_bad, runt;
  logic        wr_en, good_evt;
  logic [1:0]  drop_inc;

  // A frame starts on any qualified sof except while a frame is held and not being released.
  assign start      = rx_vld & rx_sof & ((state != ST_HOLD) | pkt_rel);
  assign frame_byte = start | (rx_vld & (state == ST_RECV));

  always_comb begin
    pos      = start ? 11'd0 : idx;
    addr_pos = pos - 11'(DST_OFF);
    in_dst   = addr_pos < 11'd6;
    mac_ok_n = start | mac_ok;
    bc_ok_n  = start | bc_ok;
    if (in_dst) begin
      mac_ok_n = mac_ok_n & (rx_dat == mac_byte(MY_MAC, addr_pos[2:0]));
      bc_ok_n  = bc_ok_n & (rx_dat == mac_byte(ETH_BCAST, addr_pos[2:0]));
    end
    hdr_bad = (in_dst & ~mac_ok_n & ~bc_ok_n)
            | ((pos == 11'(TYPE_OFF))     & (rx_dat != ETHERTYPE[15:8]))
            | ((pos == 11'(TYPE_OFF + 1)) & (rx_dat != ETHERTYPE[7:0]));
    runt    = ({1'b0, pos} + 12'd1) < 12'(HDR_LEN);
    idx_nxt = (pos == 11'h7FF) ? pos : pos + 11'd1;
  end

  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    good_evt  = 1'b0;
    drop_inc  = 2'd0;
    case (state)
      ST_RECV: if (rx_vld & rx_sof) drop_inc = 2'd1;
      ST_DROP: begin
        if (rx_vld & rx_sof) drop_inc = 2'd1;
        else if (rx_vld & rx_eof) begin
          drop_inc  = 2'd1;
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // skip marks an ignored frame in flight; it is counted once, at its end or at release.
        if (skip & (pkt_rel | (rx_vld & (rx_sof | rx_eof)))) drop_inc = 2'd1;
        if (pkt_rel) begin
          state_nxt = ST_IDLE;
          skip_nxt  = 1'b0;
        end else if (rx_vld & rx_sof) begin
          skip_nxt = ~rx_eof;
          if (rx_eof) drop_inc = drop_inc + 2'd1;
        end else if (rx_vld & rx_eof) begin
          skip_nxt = 1'b0;
        end
      end
      default: ;
    endcase
    if (frame_byte) begin
      if (rx_eof) begin
        if (rx_err | runt | hdr_bad) begin
          drop_inc  = drop_inc + 2'd1;
          state_nxt = ST_IDLE;
        end else begin
          good_evt  = 1'b1;
          state_nxt = ST_HOLD;
        end
      end else begin
        state_nxt = hdr_bad ? ST_DROP : ST_RECV;
      end
    end
  end

  always_comb begin
    pkt_rdy = (state == ST_HOLD);
    wr_en   = frame_byte & ({1'b0, pos} < 12'(DEPTH));
  end

  always_ff @(posedge clk_mac or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 11'd0;
      mac_ok    <= 1'b0;
      bc_ok     <= 1'b0;
      skip      <= 1'b0;
      pkt_len   <= 11'd0;
      pkt_trunc <= 1'b0;
      good_cnt  <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      skip <= skip_nxt;
      if (frame_byte) begin
        idx    <= idx_nxt;
        mac_ok <= mac_ok_n;
        bc_ok  <= bc_ok_n;
      end
      if (good_evt) begin
        pkt_len   <= rx_len;
        pkt_trunc <= {1'b0, rx_len} > 12'(DEPTH);
        good_cnt  <= sat_add(good_cnt, 2'd1);
      end
      if (drop_inc != 2'd0) drop_cnt <= sat_add(drop_cnt, drop_inc);
    end
  end

  rx_buf_ram #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk     (clk_mac),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (pos[AW-1:0]),
    .wr_dat  (rx_dat),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

endmodule

// File: tb/tb_rx_pkt_capture.sv
// tb/tb_rx_pkt_capture.sv - self-checking bench for rx_pkt_capture: vector table, corner sequences, random frames vs frame-level model
module tb_rx_pkt_capture;

  localparam logic [47:0] MY_MAC = 48'h020000000001;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] OTHER  = 48'h020000000002;
  localparam logic [15:0] ETYPE  = 16'hEBEB;
  localparam int          DEPTH  = 64;
  localparam int          NT     = 13;

  logic        clk_mac = 1'b0, rst_n = 1'b0;
  logic        rx_vld = 1'b0, rx_sof = 1'b0, rx_eof = 1'b0, rx_err = 1'b0, pkt_rel = 1'b0;
  logic [7:0]  rx_dat = 8'd0;
  logic [10:0] rx_len = 11'd0;
  logic [5:0]  rd_addr = 6'd0;
  logic        pkt_rdy, pkt_trunc;
  logic [10:0] pkt_len;
  logic [7:0]  rd_dat;
  logic [15:0] good_cnt, drop_cnt;

  rx_pkt_capture #(.MY_MAC(MY_MAC), .ETHERTYPE(ETYPE), .DEPTH(DEPTH)) dut (
    .clk_mac(clk_mac), .rst_n(rst_n), .rx_vld(rx_vld), .rx_dat(rx_dat), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .rx_len(rx_len), .rx_err(rx_err), .pkt_rdy(pkt_rdy), .pkt_len(pkt_len),
    .pkt_trunc(pkt_trunc), .rd_addr(rd_addr), .rd_dat(rd_dat), .pkt_rel(pkt_rel),
    .good_cnt(good_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk_mac = ~clk_mac;

  typedef struct {
    logic [47:0] mac;
    logic [15:0] et;
    int          n;
    logic        err;
    logic        exp_ok;
    logic        exp_trunc;
  } vec_t;

  vec_t       tbl [NT];
  int         n_pass = 0, n_total = 0;
  logic [7:0] fq [$];
  logic       held = 1'b0, pend = 1'b0, rdy_at_eof = 1'b0;
  int         held_len = 0, exp_good = 0, exp_drop = 0;
  logic [7:0] held_mem [DEPTH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick;
    @(posedge clk_mac);
    #1;
  endtask

  task automatic rd(input int a, output logic [7:0] d);
    rd_addr = 6'(a);
    tick;
    d = rd_dat;
  endtask

  task automatic build(input logic [47:0] mac, input logic [15:0] et, input int n, input logic [7:0] salt);
    logic [7:0] b;
    fq.delete();
    for (int i = 0; i < n; i++) begin
      if (i < 6)        b = mac[47-8*i -: 8];
      else if (i < 12)  b = 8'(i) + 8'h10;
      else if (i == 12) b = et[15:8];
      else if (i == 13) b = et[7:0];
      else              b = (8'(i) ^ 8'hCC) + salt;
      fq.push_back(b);
    end
  endtask

  // Frame-level reference: a complete frame is either captured or dropped, from the header rules alone.
  task automatic model_frame(input int n, input logic err);
    logic [47:0] dst;
    logic [15:0] et;
    logic        ok;
    if (held) begin
      exp_drop++;
      return;
    end
    ok = 1'b0;
    if (n >= 14 && !err) begin
      dst = {fq[0], fq[1], fq[2], fq[3], fq[4], fq[5]};
      et  = {fq[12], fq[13]};
      ok  = (dst == MY_MAC || dst == BCAST) && et == ETYPE;
    end
    if (ok) begin
      held = 1'b1;
      held_len = n;
      for (int i = 0; i < n && i < DEPTH; i++) held_mem[i] = fq[i];
      exp_good++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic send_frame(input int n, input logic err, input bit with_eof, input bit rel_sof, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_vld = 1'b0; rx_dat = 8'($urandom); rx_sof = 1'($urandom);
        rx_eof = 1'($urandom); rx_err = 1'($urandom); pkt_rel = 1'b0;
        repeat ($urandom_range(1, 2)) tick;
      end
      rx_vld  = 1'b1;
      rx_dat  = fq[i];
      rx_sof  = (i == 0);
      rx_eof  = with_eof && (i == n - 1);
      rx_len  = rx_eof ? 11'(n) : 11'($urandom);
      rx_err  = rx_eof ? err : 1'($urandom);
      pkt_rel = rel_sof && (i == 0);
      if (rx_eof) rdy_at_eof = pkt_rdy;
      tick;
    end
    rx_vld = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_err = 1'b0; pkt_rel = 1'b0;
  endtask

  // An eof-less frame is only counted when the next frame (or a release) ends it.
  task automatic run_frame(input int n, input logic err, input bit with_eof, input bit rel_sof, input bit gaps);
    if (pend) begin exp_drop++; pend = 1'b0; end
    if (rel_sof) held = 1'b0;
    send_frame(n, err, with_eof, rel_sof, gaps);
    if (with_eof) model_frame(n, err);
    else pend = 1'b1;
  endtask

  task automatic release_pulse;
    pkt_rel = 1'b1;
    tick;
    pkt_rel = 1'b0;
    if (held) begin
      if (pend) begin exp_drop++; pend = 1'b0; end
      held = 1'b0;
    end
  endtask

  task automatic check_state(input string nm, input bit all_b);
    int bad, lim, a;
    logic [7:0] d;
    chk({nm, "_rdy"}, 32'(pkt_rdy), 32'(held));
    chk({nm, "_good"}, 32'(good_cnt), 32'(exp_good));
    chk({nm, "_drop"}, 32'(drop_cnt), 32'(exp_drop));
    if (held) begin
      chk({nm, "_len"}, 32'(pkt_len), 32'(held_len));
      chk({nm, "_trunc"}, 32'(pkt_trunc), 32'(held_len > DEPTH));
      bad = 0;
      lim = (held_len < DEPTH) ? held_len : DEPTH;
      for (int k = 0; k < (all_b ? lim : 4); k++) begin
        a = all_b ? k : $urandom_range(0, lim - 1);
        rd(a, d);
        if (d !== held_mem[a]) bad++;
      end
      chk({nm, "_bytes_bad"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    tbl[0]  = '{BCAST,  ETYPE,    64, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{OTHER,  ETYPE,    64, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{OTHER,  ETYPE,    64, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{MY_MAC, ETYPE,   100, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{MY_MAC, 16'h0800, 64, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{BCAST,  ETYPE,    10, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{MY_MAC, ETYPE,    14, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{MY_MAC, ETYPE,    13, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{MY_MAC, ETYPE,    65, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{48'hFFFFFFFFFFFE, ETYPE, 40, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{48'h02FFFFFFFFFF, ETYPE, 40, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{MY_MAC, 16'hEBEA, 40, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{BCAST,  ETYPE,    64, 1'b1, 1'b0, 1'b0};

    repeat (2) tick;
    chk("rst_rdy", 32'(pkt_rdy), 32'd0);
    chk("rst_len", 32'(pkt_len), 32'd0);
    chk("rst_trunc", 32'(pkt_trunc), 32'd0);
    chk("rst_rd_dat", 32'(rd_dat), 32'd0);
    chk("rst_good", 32'(good_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk_mac) rst_n = 1'b1;
    tick;

    for (int i = 0; i < NT; i++) begin
      build(tbl[i].mac, tbl[i].et, tbl[i].n, 8'h00);
      run_frame(tbl[i].n, tbl[i].err, 1'b1, 1'b0, (i % 2) == 1);
      chk($sformatf("tbl%0d_rdy_during_eof", i), 32'(rdy_at_eof), 32'd0);
      chk($sformatf("tbl%0d_rdy_vec", i), 32'(pkt_rdy), 32'(tbl[i].exp_ok));
      if (tbl[i].exp_ok) chk($sformatf("tbl%0d_trunc_vec", i), 32'(pkt_trunc), 32'(tbl[i].exp_trunc));
      check_state($sformatf("tbl%0d", i), 1'b1);
      if (i == 0) begin
        rd(18, d);
        chk("bcast_byte18", 32'(d), 32'hDE);
      end
      release_pulse;
      check_state($sformatf("tbl%0d_rel", i), 1'b0);
    end

    build(MY_MAC, ETYPE, 1, 8'h00);
    run_frame(1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("single_byte", 1'b0);

    build(MY_MAC, ETYPE, 50, 8'h11);
    run_frame(50, 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("hold_a", 1'b1);
    build(BCAST, ETYPE, 50, 8'h22);
    run_frame(50, 1'b0, 1'b1, 1'b0, 1'b1);
    check_state("hold_b_ignored", 1'b1);
    build(MY_MAC, ETYPE, 30, 8'h33);
    run_frame(30, 1'b0, 1'b1, 1'b1, 1'b0);
    check_state("rel_at_sof", 1'b1);
    release_pulse;
    check_state("rel_at_sof_done", 1'b0);

    build(MY_MAC, ETYPE, 30, 8'h44);
    run_frame(20, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("no_eof", 1'b0);
    build(BCAST, ETYPE, 40, 8'h55);
    run_frame(40, 1'b0, 1'b1, 1'b0, 1'b1);
    check_state("after_no_eof", 1'b1);
    release_pulse;

    for (int f = 0; f < 40; f++) begin
      int          sel, n;
      logic [47:0] mac;
      logic [15:0] et;
      logic        err;
      bit          eof_b, rel_b;
      sel = $urandom_range(0, 3);
      if (sel == 0)      mac = MY_MAC;
      else if (sel == 1) mac = BCAST;
      else if (sel == 2) mac = {16'($urandom), 32'($urandom)};
      else               mac = MY_MAC ^ (48'h1 << (8 * $urandom_range(0, 5)));
      et    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : ETYPE;
      n     = $urandom_range(8, 90);
      err   = ($urandom_range(0, 9) == 0);
      eof_b = ($urandom_range(0, 11) != 0);
      rel_b = held && ($urandom_range(0, 2) == 0);
      build(mac, et, n, 8'($urandom));
      run_frame(n, err, eof_b, rel_b, 1'b1);
      check_state($sformatf("rnd%0d", f), 1'b0);
      if (held && $urandom_range(0, 2) == 0) begin
        release_pulse;
        check_state($sformatf("rnd%0d_rel", f), 1'b0);
      end
    end

    release_pulse;
    build(MY_MAC, ETYPE, 40, 8'h66);
    send_frame(20, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rdy", 32'(pkt_rdy), 32'd0);
    chk("async_rst_len", 32'(pkt_len), 32'd0);
    chk("async_rst_trunc", 32'(pkt_trunc), 32'd0);
    chk("async_rst_rd_dat", 32'(rd_dat), 32'd0);
    chk("async_rst_good", 32'(good_cnt), 32'd0);
    chk("async_rst_drop", 32'(drop_cnt), 32'd0);
    tick;
    @(negedge clk_mac) rst_n = 1'b1;
    exp_good = 0; exp_drop = 0; held = 1'b0; pend = 1'b0;
    tick;
    for (int i = 20; i < 40; i++) begin
      rx_vld = 1'b1; rx_dat = fq[i]; rx_sof = 1'b0; rx_eof = (i == 39);
      rx_len = 11'd40; rx_err = 1'b0;
      tick;
    end
    rx_vld = 1'b0; rx_eof = 1'b0;
    check_state("post_rst_tail", 1'b0);
    build(MY_MAC, ETYPE, 40, 8'h77);
    run_frame(40, 1'b0, 1'b1, 1'b0, 1'b0);
    check_state("post_rst_frame", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_pkt_capture.md
RX_PKT_CAPTURE -- requirements
Module: rx_pkt_capture

Interface
REQ-001 Parameter MY_MAC, 48'h020000000001, station address accepted besides broadcast.
REQ-002 Parameter ETHERTYPE, 16'hEBEB, the only accepted type field (bytes 12-13, big-endian).
REQ-003 Parameter DEPTH, 64, buffer bytes; power of two; AW = log2(DEPTH).
REQ-004 clk_mac  in  1  MAC byte clock; all logic on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rx_vld  in  1  byte strobe from MAC receive path; no backpressure.
REQ-007 rx_dat  in  8  frame byte, destination MAC first, FCS excluded.
REQ-008 rx_sof  in  1  first byte of frame, qualified by rx_vld.
REQ-009 rx_eof  in  1  last byte of frame, qualified by rx_vld.
REQ-010 rx_len  in  11  frame byte count, valid with rx_eof.
REQ-011 rx_err  in  1  FCS/PHY error, valid with rx_eof.
REQ-012 pkt_rdy  out  1  a captured frame is held.
REQ-013 pkt_len  out  11  rx_len of held frame.
REQ-014 pkt_trunc  out  1  held frame exceeded DEPTH bytes.
REQ-015 rd_addr  in  AW  buffer read address.
REQ-016 rd_dat  out  8  buffer byte, registered.
REQ-017 pkt_rel  in  1  one-cycle pulse releasing the held frame.
REQ-018 good_cnt  out  16  frames captured, saturating.
REQ-019 drop_cnt  out  16  frames dropped, saturating.

Function
REQ-020 States IDLE, RECV, DROP, HOLD; bytes without rx_vld are ignored in all states.
REQ-021 IDLE: rx_vld&rx_sof -> RECV, byte written to address 0, byte index = 1; non-sof bytes ignored.
REQ-022 RECV: each rx_vld byte at index < DEPTH written to buffer at index; index increments, saturating at 2047.
REQ-023 Bytes 0-5 compared on arrival to MY_MAC (MSB first) or 48'hFFFFFFFFFFFF; mismatch on both -> DROP.
REQ-024 Byte 12/13 mismatch against ETHERTYPE -> DROP.
REQ-025 rx_eof in RECV: rx_err=1 or index+1 < 14 (runt) -> IDLE with drop; else -> HOLD, latch pkt_len=rx_len, pkt_trunc=(rx_len>DEPTH), good_cnt+1.
REQ-026 DROP: wait for rx_eof -> IDLE, drop_cnt+1 on exit.
REQ-027 Single byte with rx_sof&rx_eof is a runt: drop_cnt+1, stays IDLE.
REQ-028 rx_sof in RECV or DROP (missing eof): prior frame counted dropped, new frame restarts at index 0 in RECV.
REQ-029 HOLD: buffer not written; any rx_sof frame is ignored to its eof and counted dropped once.
REQ-030 pkt_rdy is high exactly in HOLD, asserting the cycle after the accepting eof byte.
REQ-031 pkt_rel in HOLD -> IDLE next cycle; pkt_rel outside HOLD ignored.
REQ-032 pkt_rel and rx_vld&rx_sof in the same HOLD cycle: frame accepted, state -> RECV.
REQ-033 rd_dat = buffer[rd_addr] one cycle after rd_addr; readable in any state, contents defined only in HOLD.
REQ-034 Counters saturate at 16'hFFFF; a good and drop event never coincide.

Reset
REQ-035 rst_n low: state IDLE, pkt_rdy=0, pkt_len=0, pkt_trunc=0, rd_dat=0, good_cnt=0, drop_cnt=0, index=0.
REQ-036 Reset mid-frame discards the frame uncounted; buffer contents are not cleared.
REQ-037 After release, the first frame is accepted only from its rx_sof.

Structure
REQ-038 Shared package eth_pkg holds ETH_BCAST, header offsets (DST=0, TYPE=12, HDR_LEN=14), default ETHERTYPE and the state encoding.
REQ-039 Buffer is sub-module rx_buf_ram: simple dual-port, one write port, one registered read port, DEPTH x 8.

Verification
REQ-040 Broadcast 64-byte frame, type EBEB, rx_len=64, rx_err=0 -> pkt_rdy=1 one cycle after eof, pkt_len=64, pkt_trunc=0, rd_addr 18 -> rd_dat 8'hDE next cycle, good_cnt=1.
REQ-041 Frame to 02:00:00:00:00:02 -> no pkt_rdy, drop_cnt=1; same frame with rx_err=1 on eof -> drop_cnt=2.
REQ-042 100-byte valid frame -> pkt_len=100, pkt_trunc=1, bytes 0-63 intact.
REQ-043 Second valid frame while held -> drop_cnt+1, held bytes unchanged; pkt_rel coincident with third frame's sof -> third frame captured.
REQ-044 10-byte frame -> runt drop; sof with no eof then new sof -> drop_cnt+1, second frame captured.
REQ-045 rst_n low mid-RECV -> all outputs 0 asynchronously, counters unchanged by discarded frame.
